// File: rtl/tcp_m2s_dma_if.sv
// tcp_m2s_dma_if: signal bundle for tcp_m2s_dma.
// Carries the descriptor handshake, the AXI4 read master channels,
// the AXIS byte stream toward the tx stream demux, and the status outputs.
// The master modport is the DMA side; the slave modport is the environment side.
interface tcp_m2s_dma_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DEST_WIDTH = 8
);
  logic                  s_desc_valid;
  logic                  s_desc_ready;
  logic [ADDR_WIDTH-1:0] s_desc_addr;
  logic [LEN_WIDTH-1:0]  s_desc_len;
  logic [DEST_WIDTH-1:0] s_desc_dest;

  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;

  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;

  logic [7:0]            m_axis_tdata;
  logic [0:0]            m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic [DEST_WIDTH-1:0] m_axis_tdest;
  logic [0:0]            m_axis_tuser;

  logic                  o_done;
  logic                  o_err;
  logic                  o_busy;

  modport master (
    input  s_desc_valid, s_desc_addr, s_desc_len, s_desc_dest,
    output s_desc_ready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tuser,
    input  m_axis_tready,
    output o_done, o_err, o_busy
  );

  modport slave (
    output s_desc_valid, s_desc_addr, s_desc_len, s_desc_dest,
    input  s_desc_ready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tuser,
    output m_axis_tready,
    input  o_done, o_err, o_busy
  );
endinterface

// File: rtl/tcp_m2s_dma.sv
// tcp_m2s_dma: memory-to-stream DMA feeding the TCP tx stream demux.
// Takes one descriptor (byte address, byte count, destination), reads the
// covering 32-bit words one AXI4 single-beat read at a time and emits the
// selected bytes little-endian on an 8-bit AXIS stream with tlast on the
// final byte.
// Optional feature: define TCP_M2S_DMA_ERR_EN to honour rresp. A failed read
// terminates the frame with a 0x00 byte flagged by tuser (if any byte was
// already sent) and reports o_err with o_done.
module tcp_m2s_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int DEST_WIDTH = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  tcp_m2s_dma_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AR     = 3'd1;
  localparam logic [2:0] ST_R      = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_TWO  = {{(LEN_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [DEST_WIDTH-1:0] dest_r;
  logic [31:0]           word_r;
  logic [7:0]            tdata_r;
  logic                  desc_ready_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic                  tvalid_r;
  logic                  tlast_r;
  logic                  tuser_r;
  logic                  done_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  emitted_r;   // at least one byte of this frame accepted
  logic                  err_flag_r;  // frame hit a read error
  logic                  err_byte_r;  // current tvalid byte is the error terminator

  logic [ADDR_WIDTH-1:0] next_addr_s;
  logic [LEN_WIDTH-1:0]  next_rem_s;
  logic                  rresp_bad_s;
  logic                  unused_s;

  // Pick byte lane 0..3 of a little-endian 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
  endfunction

  // Byte-advance arithmetic and read-error qualification.
  always_comb begin
    next_addr_s = cur_addr_r + ADDR_ONE;
    next_rem_s  = remaining_r - LEN_ONE;
`ifdef TCP_M2S_DMA_ERR_EN
    rresp_bad_s = (bus.m_axi_rresp != 2'b00);
`else
    rresp_bad_s = 1'b0;
`endif
  end

  // Single-beat reads: rlast carries no information; rresp only matters with error handling.
  assign unused_s = ^{bus.m_axi_rlast, bus.m_axi_rresp};

  // Descriptor / read / stream sequencer with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= '0;
      remaining_r  <= '0;
      dest_r       <= '0;
      word_r       <= 32'd0;
      tdata_r      <= 8'd0;
      desc_ready_r <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tuser_r      <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      emitted_r    <= 1'b0;
      err_flag_r   <= 1'b0;
      err_byte_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.s_desc_valid && desc_ready_r) begin
            cur_addr_r   <= bus.s_desc_addr;
            remaining_r  <= bus.s_desc_len;
            dest_r       <= bus.s_desc_dest;
            desc_ready_r <= 1'b0;
            busy_r       <= 1'b1;
            emitted_r    <= 1'b0;
            err_flag_r   <= 1'b0;
            if (bus.s_desc_len == '0) begin
              state_r <= ST_DONE;
            end else begin
              state_r   <= ST_AR;
              arvalid_r <= 1'b1;
            end
          end else begin
            desc_ready_r <= 1'b1;
          end
        end
        ST_AR: begin
          if (bus.m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_R;
          end
        end
        ST_R: begin
          if (bus.m_axi_rvalid) begin
            rready_r <= 1'b0;
            if (rresp_bad_s) begin
              err_flag_r <= 1'b1;
              if (emitted_r) begin
                tvalid_r   <= 1'b1;
                tdata_r    <= 8'h00;
                tlast_r    <= 1'b1;
                tuser_r    <= 1'b1;
                err_byte_r <= 1'b1;
                state_r    <= ST_STREAM;
              end else begin
                state_r <= ST_DONE;
              end
            end else begin
              word_r   <= bus.m_axi_rdata;
              tvalid_r <= 1'b1;
              tdata_r  <= lane_byte(bus.m_axi_rdata, cur_addr_r[1:0]);
              tlast_r  <= (remaining_r == LEN_ONE);
              state_r  <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (bus.m_axis_tready) begin
            emitted_r <= 1'b1;
            if (err_byte_r) begin
              tvalid_r   <= 1'b0;
              tlast_r    <= 1'b0;
              tuser_r    <= 1'b0;
              err_byte_r <= 1'b0;
              state_r    <= ST_DONE;
            end else begin
              cur_addr_r  <= next_addr_s;
              remaining_r <= next_rem_s;
              if (remaining_r == LEN_ONE) begin
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                state_r  <= ST_DONE;
              end else if (cur_addr_r[1:0] == 2'b11) begin
                tvalid_r  <= 1'b0;
                arvalid_r <= 1'b1;
                state_r   <= ST_AR;
              end else begin
                tdata_r <= lane_byte(word_r, next_addr_s[1:0]);
                tlast_r <= (remaining_r == LEN_TWO);
              end
            end
          end
        end
        ST_DONE: begin
          done_r       <= 1'b1;
          err_r        <= err_flag_r;
          busy_r       <= 1'b0;
          desc_ready_r <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_desc_ready  = desc_ready_r;
  assign bus.m_axi_arvalid = arvalid_r;
  assign bus.m_axi_araddr  = {cur_addr_r[ADDR_WIDTH-1:2], 2'b00};
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_rready  = rready_r;
  assign bus.m_axis_tdata  = tdata_r;
  assign bus.m_axis_tkeep  = 1'b1;
  assign bus.m_axis_tvalid = tvalid_r;
  assign bus.m_axis_tlast  = tlast_r;
  assign bus.m_axis_tdest  = dest_r;
  assign bus.m_axis_tuser  = tuser_r;
  assign bus.o_done        = done_r;
  assign bus.o_err         = err_r;
  assign bus.o_busy        = busy_r;

endmodule

// File: doc/tcp_m2s_dma.md
TCP_M2S_DMA -- requirements
Module: tcp_m2s_dma

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI read address width.
REQ-002 Parameter LEN_WIDTH, default 16, descriptor byte-length width.
REQ-003 Parameter DEST_WIDTH, default 8, AXIS tdest width; equals the tx stream demux route width.
REQ-004 Port i_clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port i_rst  input  1  asynchronous active-high reset.
REQ-006 Ports s_desc_valid/s_desc_ready  in/out  1/1  descriptor handshake.
REQ-007 Ports s_desc_addr/s_desc_len/s_desc_dest  input  ADDR_WIDTH/LEN_WIDTH/DEST_WIDTH  start byte address, byte count, target stream.
REQ-008 Ports m_axi_arvalid/arready/araddr/arlen/arsize/arburst  AXI4 read-address master; arlen=0, arsize=3'b010, arburst=2'b01 constant.
REQ-009 Ports m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]/rlast  AXI4 read-data master.
REQ-010 Ports m_axis_tdata[7:0], tkeep[0], tvalid, tready, tlast, tdest[DEST_WIDTH-1:0], tuser[0]  byte stream to tx stream demux.
REQ-011 Ports o_done/o_err  output  1/1  single-cycle completion pulse, error flag qualified by o_done.
REQ-012 Port o_busy  output  1  high from descriptor accept until o_done.

Function
REQ-013 States IDLE, AR, R, STREAM, DONE; one outstanding AXI read at a time.
REQ-014 IDLE: s_desc_ready=1; on valid&ready latch addr, len, dest; len==0 -> DONE, else -> AR.
REQ-015 AR: araddr = {cur_addr[ADDR_WIDTH-1:2],2'b00}; hold arvalid until arready, then -> R.
REQ-016 R: rready=1; on rvalid capture rdata into word buffer -> STREAM.
REQ-017 STREAM: emit bytes little-endian starting at lane cur_addr[1:0], through lane 3 or until remaining==0.
REQ-018 Each accepted byte (tvalid&tready): cur_addr+=1, remaining-=1; tdata, tdest, tlast held stable while tvalid&!tready.
REQ-019 tlast=1 exactly on the byte where remaining==1; tkeep=1 always; tuser=0 except REQ-027.
REQ-020 After lane 3 with remaining>0 -> AR (next word); after remaining reaches 0 -> DONE.
REQ-021 DONE: o_done=1 for one cycle, o_err per REQ-027, -> IDLE; s_desc_ready=0 in DONE.
REQ-022 Address wrap at 2^ADDR_WIDTH wraps to 0 silently; remaining computed in LEN_WIDTH, max len 2^LEN_WIDTH-1.
REQ-023 Descriptor latency: accept to first arvalid exactly 1 cycle; rvalid to first tvalid exactly 1 cycle.
REQ-024 Bytes of an unaligned first word below cur_addr[1:0] and bytes beyond len are discarded, never emitted.

Reset
REQ-025 i_rst asserted: state=IDLE immediately; arvalid, rready, tvalid, tlast, tuser, o_done, o_err, o_busy = 0; s_desc_ready = 0 during reset, 1 first cycle after deassertion.
REQ-026 Reset mid-frame abandons the frame without tlast; an in-flight AXI read response after reset is not expected (system reset).

Configuration
REQ-027 Macro TCP_M2S_DMA_ERR_EN defined: rresp!=2'b00 in R discards the word; if any byte of the frame was already emitted, emit one byte 0x00 with tlast=1, tuser=1, then DONE with o_err=1; if none emitted, go straight to DONE with o_err=1.
REQ-028 Macro undefined: rresp ignored, data used as returned, o_err tied 0, tuser tied 0.

Verification
REQ-029 Desc addr=0x100, len=4, dest=3, tready=1 -> one AR at 0x100; bytes rdata[7:0]..[31:24], tdest=3, tlast on 4th, o_done 1 cycle.
REQ-030 Desc addr=0x103, len=6 -> ARs at 0x100, 0x104; bytes: lane3 of word0 then lanes0..3 of word1, then AR 0x108 lane0; tlast on 6th byte.
REQ-031 len=0 -> no AR, no tvalid, o_done pulses 2 cycles after accept, o_err=0.
REQ-032 tready toggled 1/0 every cycle, len=9 -> 9 bytes in order, data/tlast stable during stalls, no duplicates.
REQ-033 ERR_EN: len=8, second read returns rresp=2'b10 -> 4 good bytes then 0x00 with tlast=1,tuser=1, o_done&o_err=1; without ERR_EN -> 8 bytes, o_err=0.
REQ-034 Assert i_rst in STREAM with tvalid=1 -> tvalid=0 same cycle; after release new descriptor len=2 completes normally.
